ram_sync: RTL and testbench

RAM_SYNC -- requirements
Module: ram_sync

---
 rtl/ram_pkg.sv | 12 +
 rtl/ram_sync_if.sv | 24 ++
 rtl/ram_sync_pipe.sv | 37 +++
 rtl/ram_sync.sv | 117 +++++++++++
 tb/tb_ram_sync.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared constants and types for the synchronous RAM with sequential clear.
package ram_pkg;

  localparam bit READ_FIRST  = 1'b0;
  localparam bit WRITE_FIRST = 1'b1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/ram_sync_if.sv
// Access port of ram_sync: request side driven by the master, return side by the RAM.
interface ram_sync_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              clr;
  logic              ready;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;

  modport master (
    output en, we, addr, din, clr,
    input  ready, dout, dout_valid
  );

  modport slave (
    input  en, we, addr, din, clr,
    output ready, dout, dout_valid
  );
endinterface

// File: rtl/ram_sync_pipe.sv
// Extra return-data delay stages; data registers only load with a valid word so
// the output keeps its last value between pulses.
module ram_sync_pipe #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             valid_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of its neighbour, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) data_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/ram_sync.sv
// Single-port synchronous RAM that zeroes itself one word per cycle after reset
// or on request, then serves one read/write per cycle with RD_LAT latency.
module ram_sync
  import ram_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 1,
  parameter bit WR_MODE = READ_FIRST
) (
  input logic       clk,
  input logic       rst,
  ram_sync_if.slave bus
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_c;
  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_c   = 1'b0;
    accept    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = bus.addr;
    mem_wdata = bus.din;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        ready_c = 1'b1;
        // A clear request takes priority and silently drops a same-cycle access.
        if (bus.clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (bus.en) begin
          accept = 1'b1;
          mem_we = bus.we;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: the array has no reset so it can map onto block RAM; the CLEAR walk is
  // what gives it defined contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // First return stage: the array read sees the pre-edge word (READ_FIRST).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= accept;
      if (accept) begin
        rd_data_q <= (bus.we && WR_MODE == WRITE_FIRST) ? bus.din : mem[bus.addr];
      end
    end
  end

  generate
    if (RD_LAT > 1) begin : g_pipe
      ram_sync_pipe #(
        .DATA_W (DATA_W),
        .DEPTH  (RD_LAT - 1)
      ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_data   (rd_data_q),
        .in_valid  (rd_valid_q),
        .out_data  (bus.dout),
        .out_valid (bus.dout_valid)
      );
    end else begin : g_direct
      assign bus.dout       = rd_data_q;
      assign bus.dout_valid = rd_valid_q;
    end
  endgenerate

  assign bus.ready = ready_c;

endmodule

// File: tb/tb_ram_sync.sv
// Runs a RD_LAT=1/READ_FIRST and a RD_LAT=2/WRITE_FIRST instance side by side
// against a queue-based reference model plus directed literal expectations.
module tb_ram_sync;
  import ram_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, we, clr;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  int            edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  ram_sync_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  ram_sync_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  assign bus0.en = en;   assign bus1.en = en;
  assign bus0.we = we;   assign bus1.we = we;
  assign bus0.addr = addr; assign bus1.addr = addr;
  assign bus0.din = din; assign bus1.din = din;
  assign bus0.clr = clr; assign bus1.clr = clr;

  ram_sync #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .WR_MODE(READ_FIRST)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  ram_sync #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .WR_MODE(WRITE_FIRST)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  logic          act_valid [2];
  logic          act_ready [2];
  logic [DW-1:0] act_dout  [2];
  assign act_valid[0] = bus0.dout_valid; assign act_valid[1] = bus1.dout_valid;
  assign act_ready[0] = bus0.ready;      assign act_ready[1] = bus1.ready;
  assign act_dout[0]  = bus0.dout;       assign act_dout[1]  = bus1.dout;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  // Reference model: array contents, remaining clear cycles, and a queue of
  // returns each counting down the edges until its pulse.
  typedef struct {
    int            rem;
    logic [DW-1:0] data;
  } pend_t;

  pend_t         pend_q [2][$];
  logic [DW-1:0] mdl_mem [2][DEPTH];
  int            clear_left [2];
  logic [DW-1:0] held [2];
  int            last_vedge [2];
  int            vcount [2];
  logic [DW-1:0] last_vdata [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      last_vedge[k] = 0;
      vcount[k]     = 0;
      last_vdata[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          pend_q[k].delete();
          clear_left[k] = DEPTH;
          held[k]       = '0;
          for (int a = 0; a < DEPTH; a++) mdl_mem[k][a] = '0;
          check($sformatf("rst_valid%0d", k), act_valid[k], 0);
          check($sformatf("rst_ready%0d", k), act_ready[k], 0);
          check($sformatf("rst_dout%0d", k), act_dout[k], 0);
        end else begin
          logic          exp_v;
          pend_t         p;
          logic [DW-1:0] d;
          exp_v = 1'b0;
          for (int i = 0; i < pend_q[k].size(); i++) pend_q[k][i].rem--;
          if (pend_q[k].size() > 0 && pend_q[k][0].rem == 0) begin
            p       = pend_q[k].pop_front();
            exp_v   = 1'b1;
            held[k] = p.data;
          end
          check($sformatf("cyc_valid%0d@%0d", k, edge_cnt), act_valid[k], exp_v);
          check($sformatf("cyc_dout%0d@%0d", k, edge_cnt), act_dout[k], held[k]);
          check($sformatf("cyc_ready%0d@%0d", k, edge_cnt), act_ready[k], clear_left[k] == 0);
          if (act_valid[k] === 1'b1) begin
            last_vedge[k] = edge_cnt + 1;
            vcount[k]++;
            last_vdata[k] = act_dout[k];
          end
          // Advance the model across the upcoming edge using the settled inputs.
          if (clear_left[k] > 0) begin
            clear_left[k]--;
          end else if (clr) begin
            clear_left[k] = DEPTH;
            for (int a = 0; a < DEPTH; a++) mdl_mem[k][a] = '0;
          end else if (en) begin
            d = (we && k == 1) ? din : mdl_mem[k][addr];
            if (we) mdl_mem[k][addr] = din;
            p.rem  = lat_of(k);
            p.data = d;
            pend_q[k].push_back(p);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic c,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    en = e; we = w; clr = c; addr = a; din = d;
  endtask

  task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int acc);
    drive(1'b1, w, 1'b0, a, d);
    tick();
    acc = edge_cnt;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!(bus0.ready === 1'b1 && bus1.ready === 1'b1) && n < 400) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n, v0, v1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) tick();
    rst = 1'b0;

    wait_ready(n);
    check("init_ready_cycles", n, 256);

    access(1'b0, 8'h7F, '0, acc);
    repeat (3) tick();
    check("rd7f_data_lat1", last_vdata[0], 16'h0000);
    check("rd7f_data_lat2", last_vdata[1], 16'h0000);

    access(1'b1, 8'h10, 16'hBEEF, acc);
    access(1'b0, 8'h10, '0, acc);
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("raw_data%0d", k), last_vdata[k], 16'hBEEF);
      check($sformatf("raw_edge%0d", k), last_vedge[k], acc + lat_of(k));
    end

    access(1'b1, 8'h20, 16'hAAAA, acc);
    access(1'b1, 8'h20, 16'h1234, acc);
    repeat (3) tick();
    check("wr_ret_read_first", last_vdata[0], 16'hAAAA);
    check("wr_ret_write_first", last_vdata[1], 16'h1234);

    for (int i = 0; i < 4; i++) access(1'b1, AW'(i), DW'(16'hC000 + i), acc);
    repeat (3) tick();
    v1 = vcount[1];
    for (int i = 0; i < 4; i++) access(1'b0, AW'(i), '0, acc);
    repeat (4) tick();
    check("burst_pulses_lat2", vcount[1] - v1, 4);
    check("burst_last_data_lat2", last_vdata[1], 16'hC003);
    check("burst_last_edge_lat2", last_vedge[1], acc + 2);

    // Read in flight when clr arrives together with a write that must be dropped.
    v1 = vcount[1];
    access(1'b0, 8'h03, '0, acc);
    drive(1'b1, 1'b1, 1'b1, 8'h30, 16'h5555);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    wait_ready(n);
    check("clr_ready_cycles", n, 256);
    check("inflight_done_pulses", vcount[1] - v1, 1);
    check("inflight_done_data", last_vdata[1], 16'hC003);
    access(1'b0, 8'h30, '0, acc);
    repeat (3) tick();
    check("clr_rd30_lat1", last_vdata[0], 16'h0000);
    check("clr_rd30_lat2", last_vdata[1], 16'h0000);

    // Reset discards a pending return; en during CLEAR is ignored.
    v0 = vcount[0];
    v1 = vcount[1];
    drive(1'b1, 1'b0, 1'b0, 8'h02, '0);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'h40, 16'h9999);
    repeat (100) tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check("rst_flush_pulses_lat2", vcount[1] - v1, 0);
    check("clear_en_ignored_lat1", vcount[0] - v0, 0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    wait_ready(n);
    check("rst_mid_clear_ready_cycles", n, 256);
    access(1'b0, 8'h40, '0, acc);
    repeat (3) tick();
    check("rd40_after_clear_lat1", last_vdata[0], 16'h0000);
    check("rd40_after_clear_lat2", last_vdata[1], 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
